// File: rtl/buzzer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : buzzer_sequencer
// Purpose  : Arbitrates key/error/alarm beep requests and gates the 800 Hz
//            tone into timed on/off patterns paced by the 1 kHz tick.
// Revision : 1.0 - initial release
// ============================================================================
module buzzer_sequencer #(
    parameter int BEEP_MS      = 100,
    parameter int GAP_MS       = 100,
    parameter int ALARM_ON_MS  = 500,
    parameter int ALARM_OFF_MS = 500,
    parameter int ALARM_REPS   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_1khz,
    input  logic       clk_800hz,
    input  logic       req_key,
    input  logic       req_err,
    input  logic       req_alarm,
    input  logic       cancel,
    output logic       buzzer,
    output logic       busy,
    output logic [1:0] active_pat,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam logic [1:0] c_pat_none  = 2'b00;
    localparam logic [1:0] c_pat_key   = 2'b01;
    localparam logic [1:0] c_pat_err   = 2'b10;
    localparam logic [1:0] c_pat_alarm = 2'b11;

    // Segment lengths are stored as LEN-1, the terminal ms_cnt value.
    localparam logic [9:0] c_beep_last     = 10'(BEEP_MS - 1);
    localparam logic [9:0] c_gap_last      = 10'(GAP_MS - 1);
    localparam logic [9:0] c_alarm_on_last = 10'(ALARM_ON_MS - 1);
    localparam logic [9:0] c_alarm_off_last= 10'(ALARM_OFF_MS - 1);
    localparam logic [4:0] c_alarm_segs    = 5'(2 * ALARM_REPS - 1);

    state_t     r_state;
    state_t     w_state_nx;
    logic [1:0] r_khz_sync;
    logic       r_khz_prev;
    logic [1:0] r_tone_sync;
    logic       r_pend_key,   w_pend_key_nx;
    logic       r_pend_err,   w_pend_err_nx;
    logic       r_pend_alarm, w_pend_alarm_nx;
    logic [9:0] r_ms_cnt,     w_ms_cnt_nx;
    logic [4:0] r_seg,        w_seg_nx;
    logic [1:0] r_active_pat, w_pat_nx;
    logic       r_busy;
    logic       r_done,       w_done_nx;
    logic       r_buzzer;

    logic       w_ms_tick;
    logic [9:0] w_seg_last;
    logic [4:0] w_num_segs;
    logic [4:0] w_seg_inc;

    assign w_ms_tick = r_khz_sync[1] & ~r_khz_prev;
    assign w_seg_inc = r_seg + 5'd1;

    // Odd segments of the multi-segment patterns are the silent ones.
    always_comb begin
        w_seg_last = c_beep_last;
        w_num_segs = 5'd1;
        case (r_active_pat)
            c_pat_err: begin
                w_num_segs = 5'd3;
                w_seg_last = r_seg[0] ? c_gap_last : c_beep_last;
            end
            c_pat_alarm: begin
                w_num_segs = c_alarm_segs;
                w_seg_last = r_seg[0] ? c_alarm_off_last : c_alarm_on_last;
            end
            default: begin
                w_num_segs = 5'd1;
                w_seg_last = c_beep_last;
            end
        endcase
    end

    always_comb begin
        w_state_nx      = r_state;
        w_ms_cnt_nx     = r_ms_cnt;
        w_seg_nx        = r_seg;
        w_pat_nx        = r_active_pat;
        w_done_nx       = 1'b0;
        w_pend_key_nx   = r_pend_key   | req_key;
        w_pend_err_nx   = r_pend_err   | req_err;
        w_pend_alarm_nx = r_pend_alarm | req_alarm;

        if (cancel) begin
            w_state_nx      = ST_IDLE;
            w_ms_cnt_nx     = 10'd0;
            w_seg_nx        = 5'd0;
            w_pat_nx        = c_pat_none;
            w_pend_key_nx   = 1'b0;
            w_pend_err_nx   = 1'b0;
            w_pend_alarm_nx = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_pend_alarm) begin
                        w_pend_alarm_nx = 1'b0;
                        w_pat_nx        = c_pat_alarm;
                        w_state_nx      = ST_ON;
                        w_seg_nx        = 5'd0;
                        w_ms_cnt_nx     = 10'd0;
                    end else if (r_pend_err) begin
                        w_pend_err_nx = 1'b0;
                        w_pat_nx      = c_pat_err;
                        w_state_nx    = ST_ON;
                        w_seg_nx      = 5'd0;
                        w_ms_cnt_nx   = 10'd0;
                    end else if (r_pend_key) begin
                        w_pend_key_nx = 1'b0;
                        w_pat_nx      = c_pat_key;
                        w_state_nx    = ST_ON;
                        w_seg_nx      = 5'd0;
                        w_ms_cnt_nx   = 10'd0;
                    end
                end
                ST_ON, ST_OFF: begin
                    if (r_pend_alarm && (r_active_pat != c_pat_alarm)) begin
                        // Alarm preempts silently; the interrupted pattern is dropped.
                        w_pend_alarm_nx = 1'b0;
                        w_pat_nx        = c_pat_alarm;
                        w_state_nx      = ST_ON;
                        w_seg_nx        = 5'd0;
                        w_ms_cnt_nx     = 10'd0;
                    end else if (w_ms_tick) begin
                        if (r_ms_cnt == w_seg_last) begin
                            w_ms_cnt_nx = 10'd0;
                            w_seg_nx    = w_seg_inc;
                            if (w_seg_inc == w_num_segs) begin
                                w_state_nx = ST_IDLE;
                                w_done_nx  = 1'b1;
                                w_pat_nx   = c_pat_none;
                                w_seg_nx   = 5'd0;
                            end else begin
                                w_state_nx = w_seg_inc[0] ? ST_OFF : ST_ON;
                            end
                        end else begin
                            w_ms_cnt_nx = r_ms_cnt + 10'd1;
                        end
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_pat_nx   = c_pat_none;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_khz_sync   <= 2'b00;
            r_khz_prev   <= 1'b0;
            r_tone_sync  <= 2'b00;
            r_pend_key   <= 1'b0;
            r_pend_err   <= 1'b0;
            r_pend_alarm <= 1'b0;
            r_ms_cnt     <= 10'd0;
            r_seg        <= 5'd0;
            r_active_pat <= c_pat_none;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_buzzer     <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_khz_sync   <= {r_khz_sync[0], clk_1khz};
            r_khz_prev   <= r_khz_sync[1];
            r_tone_sync  <= {r_tone_sync[0], clk_800hz};
            r_pend_key   <= w_pend_key_nx;
            r_pend_err   <= w_pend_err_nx;
            r_pend_alarm <= w_pend_alarm_nx;
            r_ms_cnt     <= w_ms_cnt_nx;
            r_seg        <= w_seg_nx;
            r_active_pat <= w_pat_nx;
            r_busy       <= (w_state_nx != ST_IDLE);
            r_done       <= w_done_nx;
            // Cancel must silence the pin on its own edge, not one cycle later.
            r_buzzer     <= ~cancel & (r_state == ST_ON) & r_tone_sync[1];
        end
    end

    assign buzzer     = r_buzzer;
    assign busy       = r_busy;
    assign active_pat = r_active_pat;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_buzzer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_buzzer_sequencer
// Purpose  : Directed self-checking bench for buzzer_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_buzzer_sequencer;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       clk_1khz  = 1'b0;
    logic       clk_800hz = 1'b0;
    logic       req_key   = 1'b0;
    logic       req_err   = 1'b0;
    logic       req_alarm = 1'b0;
    logic       cancel    = 1'b0;
    logic       buzzer;
    logic       busy;
    logic [1:0] active_pat;
    logic       done;

    buzzer_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_1khz   (clk_1khz),
        .clk_800hz  (clk_800hz),
        .req_key    (req_key),
        .req_err    (req_err),
        .req_alarm  (req_alarm),
        .cancel     (cancel),
        .buzzer     (buzzer),
        .busy       (busy),
        .active_pat (active_pat),
        .done       (done)
    );

    always #5 clk = ~clk;

    // 1 kHz stand-in: 20-cycle period; tone: 12-cycle period.
    int khz_div  = 0;
    int tone_div = 0;
    always @(negedge clk) begin
        if (khz_div == 9) begin
            khz_div  = 0;
            clk_1khz = ~clk_1khz;
        end else begin
            khz_div = khz_div + 1;
        end
        if (tone_div == 5) begin
            tone_div  = 0;
            clk_800hz = ~clk_800hz;
        end else begin
            tone_div = tone_div + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Burst/gap monitor on the buzzer pin; gaps longer than 20 cycles split bursts.
    int         cyc = 0;
    int         done_cnt, busy_cyc, pat_bad, burst_start, last_hi, lo_run;
    logic       in_burst, have_burst, mon_pat_en;
    logic [1:0] mon_pat;
    int         bursts[$];
    int         gaps[$];

    always @(negedge clk) begin
        cyc++;
        if (done) done_cnt++;
        if (busy) busy_cyc++;
        if (mon_pat_en && busy && (active_pat != mon_pat)) pat_bad++;
        if (buzzer) begin
            if (!in_burst) begin
                if (have_burst) gaps.push_back(lo_run);
                in_burst    = 1'b1;
                have_burst  = 1'b1;
                burst_start = cyc;
            end
            last_hi = cyc;
            lo_run  = 0;
        end else begin
            lo_run++;
            if (in_burst && (lo_run > 20 || !busy)) begin
                bursts.push_back(last_hi - burst_start + 1);
                in_burst = 1'b0;
            end
        end
    end

    task automatic mon_reset(input logic [1:0] pat, input logic pat_en);
        done_cnt   = 0;
        busy_cyc   = 0;
        pat_bad    = 0;
        lo_run     = 0;
        in_burst   = 1'b0;
        have_burst = 1'b0;
        mon_pat    = pat;
        mon_pat_en = pat_en;
        bursts.delete();
        gaps.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        check_eq({tag, "_done_seen"}, 32'(done), 1);
    endtask

    initial begin
        mon_reset(2'b00, 1'b0);
        repeat (3) step();
        check_eq("rst_buzzer", 32'(buzzer), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_pat", 32'(active_pat), 0);
        check_eq("rst_done", 32'(done), 0);
        rst_n = 1'b1;
        repeat (5) step();

        // Key beep
        mon_reset(2'b01, 1'b1);
        req_key = 1'b1; step(); req_key = 1'b0;
        check_eq("key_busy_pre", 32'(busy), 0);
        step();
        check_eq("key_busy", 32'(busy), 1);
        check_eq("key_pat", 32'(active_pat), 1);
        wait_done("key", 2100);
        check_eq("key_busy_after", 32'(busy), 0);
        check_eq("key_pat_after", 32'(active_pat), 0);
        repeat (5) step();
        check_eq("key_done_cnt", done_cnt, 1);
        check_eq("key_ms", (busy_cyc + 19) / 20, 100);
        check_eq("key_bursts", bursts.size(), 1);
        check_eq("key_pat_bad", pat_bad, 0);

        // Error double beep
        mon_reset(2'b10, 1'b1);
        req_err = 1'b1; step(); req_err = 1'b0; step();
        check_eq("err_pat", 32'(active_pat), 2);
        wait_done("err", 6100);
        repeat (5) step();
        check_eq("err_done_cnt", done_cnt, 1);
        check_eq("err_ms", (busy_cyc + 19) / 20, 300);
        check_eq("err_bursts", bursts.size(), 2);
        check_eq("err_gap_ms", (gaps.size() > 0) ? (gaps[0] + 7) / 20 : 0, 100);
        check_eq("err_burst2_ms", (bursts.size() > 1) ? (bursts[1] + 12) / 20 : 0, 100);
        check_eq("err_pat_bad", pat_bad, 0);

        // Alarm: three on-segments, two gaps, no trailing gap
        mon_reset(2'b11, 1'b1);
        req_alarm = 1'b1; step(); req_alarm = 1'b0; step();
        check_eq("alm_pat", 32'(active_pat), 3);
        wait_done("alm", 50100);
        repeat (5) step();
        check_eq("alm_done_cnt", done_cnt, 1);
        check_eq("alm_ms", (busy_cyc + 19) / 20, 2500);
        check_eq("alm_bursts", bursts.size(), 3);
        check_eq("alm_gaps", gaps.size(), 2);
        check_eq("alm_gap1_ms", (gaps.size() > 1) ? (gaps[1] + 7) / 20 : 0, 500);
        check_eq("alm_burst3_ms", (bursts.size() > 2) ? (bursts[2] + 12) / 20 : 0, 500);
        check_eq("alm_pat_bad", pat_bad, 0);

        // Simultaneous key+err: err first, then key
        mon_reset(2'b00, 1'b0);
        req_key = 1'b1; req_err = 1'b1; step(); req_key = 1'b0; req_err = 1'b0; step();
        check_eq("prio_first_pat", 32'(active_pat), 2);
        wait_done("prio_err", 6100);
        check_eq("prio_idle_between", 32'(busy), 0);
        step();
        check_eq("prio_second_busy", 32'(busy), 1);
        check_eq("prio_second_pat", 32'(active_pat), 1);
        wait_done("prio_key", 2100);
        repeat (3) step();
        check_eq("prio_done_cnt", done_cnt, 2);

        // Alarm preempts key; then cancel with a key request pending and coincident
        mon_reset(2'b00, 1'b0);
        req_key = 1'b1; step(); req_key = 1'b0; step();
        check_eq("pre_key_pat", 32'(active_pat), 1);
        repeat (300) step();
        req_alarm = 1'b1; step(); req_alarm = 1'b0;
        check_eq("pre_still_key", 32'(active_pat), 1);
        step();
        check_eq("pre_alarm_pat", 32'(active_pat), 3);
        check_eq("pre_alarm_busy", 32'(busy), 1);
        repeat (2000) step();
        check_eq("pre_alarm_cont", 32'(active_pat), 3);
        check_eq("pre_no_done", done_cnt, 0);
        req_key = 1'b1; step(); req_key = 1'b0;
        repeat (20) step();
        check_eq("pend_key_waits", 32'(active_pat), 3);
        cancel = 1'b1; req_key = 1'b1; step(); cancel = 1'b0; req_key = 1'b0;
        check_eq("cxl_buzzer", 32'(buzzer), 0);
        check_eq("cxl_busy", 32'(busy), 0);
        check_eq("cxl_pat", 32'(active_pat), 0);
        check_eq("cxl_done", 32'(done), 0);
        repeat (200) step();
        check_eq("cxl_stays_idle", 32'(busy), 0);
        check_eq("cxl_no_done", done_cnt, 0);

        // Asynchronous reset mid-error pattern
        mon_reset(2'b00, 1'b0);
        req_err = 1'b1; step(); req_err = 1'b0;
        repeat (500) step();
        check_eq("rst_mid_busy_pre", 32'(busy), 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_buzzer", 32'(buzzer), 0);
        check_eq("arst_busy", 32'(busy), 0);
        check_eq("arst_pat", 32'(active_pat), 0);
        check_eq("arst_done", 32'(done), 0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (200) step();
        check_eq("arst_idle_busy", 32'(busy), 0);
        check_eq("arst_idle_pat", 32'(active_pat), 0);
        check_eq("arst_no_done", done_cnt, 0);
        req_key = 1'b1; step(); req_key = 1'b0; step();
        check_eq("arst_new_grant", 32'(active_pat), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
